// File: rtl/vx_mem_model_pkg.sv
// Shared types and helpers for the Vortex memory latency model.
// Entry layout is shared by the response queue and the top level.
package vx_mem_model_pkg;

  localparam int LAT_CNT_W  = 8;
  localparam int DEF_DATA_W = 512;
  localparam int DEF_TAG_W  = 56;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_TAG_W-1:0]  tag;
    logic [LAT_CNT_W-1:0]  countdown;
    logic                  valid;
  } rsp_entry_t;

  function automatic logic [7:0] be_merge(
    input logic [7:0] old_b,
    input logic [7:0] new_b,
    input logic       en
  );
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/vx_mem_rsp_queue.sv
// Circular FIFO of pending read responses.
// Every valid entry counts down; the head is ready at zero.
module vx_mem_rsp_queue
  import vx_mem_model_pkg::*;
#(
  parameter type entry_t = rsp_entry_t,
  parameter int  DEPTH   = 8,
  parameter int  CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output entry_t           head,
  output logic             head_ready,
  output logic [CNT_W-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && ent_q[i].countdown != '0)
        ent_d[i].countdown = ent_q[i].countdown - LAT_CNT_W'(1);
    end
    if (pop) begin
      ent_d[head_q].valid = 1'b0;
      head_d = head_q + PW'(1);
    end
    // Push never aliases the popped slot: push is blocked when full.
    if (push) begin
      ent_d[tail_q]       = push_entry;
      ent_d[tail_q].valid = 1'b1;
      tail_d = tail_q + PW'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head       = ent_q[head_q];
  assign head_ready = head.valid && (head.countdown == '0);
  assign count      = count_q;

endmodule

// File: rtl/vx_mem_latency_model.sv
// Memory responder for the Vortex mem port: byte-enabled writes,
// fixed read latency, in-order tagged responses with backpressure.
module vx_mem_latency_model
  import vx_mem_model_pkg::*;
#(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 26,
  parameter int TAG_WIDTH       = 56,
  parameter int MEM_DEPTH_LOG2  = 12,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               mem_req_valid,
  output logic                               mem_req_ready,
  input  logic                               mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0]            mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]              mem_req_addr,
  input  logic [DATA_WIDTH-1:0]              mem_req_data,
  input  logic [TAG_WIDTH-1:0]               mem_req_tag,
  output logic                               mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]              mem_rsp_data,
  output logic [TAG_WIDTH-1:0]               mem_rsp_tag,
  input  logic                               mem_rsp_ready,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int LINES = 1 << MEM_DEPTH_LOG2;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
    logic [LAT_CNT_W-1:0]  countdown;
    logic                  valid;
  } entry_t;

  logic [DATA_WIDTH-1:0]     mem_q [LINES];
  logic [MEM_DEPTH_LOG2-1:0] idx;
  logic [DATA_WIDTH-1:0]     rd_line;
  logic [DATA_WIDTH-1:0]     wr_line_d;
  logic                      accept, wr_en, push, pop;
  logic                      ready_q, ready_d;
  logic                      head_ready;
  entry_t                    push_entry, head;
  logic [OUT_W-1:0]          count, count_d;
  logic                      unused_bits;

  assign idx     = mem_req_addr[MEM_DEPTH_LOG2-1:0];
  assign rd_line = mem_q[idx];
  assign accept  = mem_req_valid && ready_q;
  assign wr_en   = accept && mem_req_rw;
  assign push    = accept && !mem_req_rw;
  assign pop     = head_ready && mem_rsp_ready;

  always_comb begin
    wr_line_d = rd_line;
    for (int b = 0; b < BYTES; b++)
      wr_line_d[b*8 +: 8] = be_merge(rd_line[b*8 +: 8],
                                     mem_req_data[b*8 +: 8],
                                     mem_req_byteen[b]);
  end

  always_comb begin
    push_entry           = '0;
    push_entry.data      = rd_line;
    push_entry.tag       = mem_req_tag;
    push_entry.countdown = LAT_CNT_W'(LATENCY - 1);
    push_entry.valid     = 1'b1;
    count_d = count + OUT_W'(push) - OUT_W'(pop);
    ready_d = count_d < OUT_W'(MAX_OUTSTANDING);
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[idx] <= wr_line_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ready_q <= 1'b0;
    else
      ready_q <= ready_d;
  end

  vx_mem_rsp_queue #(
    .entry_t (entry_t),
    .DEPTH   (MAX_OUTSTANDING),
    .CNT_W   (OUT_W)
  ) u_rsp_queue (
    .clk        (clk),
    .rst_n      (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .head_ready (head_ready),
    .count      (count)
  );

  assign mem_req_ready = ready_q;
  assign mem_rsp_valid = head_ready;
  assign mem_rsp_data  = head.data;
  assign mem_rsp_tag   = head.tag;
  assign outstanding   = count;
  assign busy          = |count;

  assign unused_bits = ^{mem_req_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2],
                         head.countdown, head.valid};

endmodule

// File: doc/vx_mem_latency_model.md
Name: vx_mem_latency_model

Overview:
- Parametrised synthesizable memory responder for the Vortex memory port.
- Successor to the zero-latency bypass RAM used in top-level benches.
- Adds byte-enabled writes, configurable fixed read latency, multiple outstanding reads with in-order tagged responses, and response backpressure.
- Sits directly on the Vortex mem_req_*/mem_rsp_* interface, in the bench or the FPGA shell.

Parameters:
- DATA_WIDTH, 512: memory line width in bits; must be a multiple of 8.
- ADDR_WIDTH, 26: request address width (line address).
- TAG_WIDTH, 56: request/response tag width.
- MEM_DEPTH_LOG2, 12: log2 of the number of lines stored.
- LATENCY, 4: minimum cycles from read accept to mem_rsp_valid; legal range 1..255.
- MAX_OUTSTANDING, 8: read-queue depth; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_req_valid  in  1  request valid.
- mem_req_ready  out  1  request accepted when valid && ready.
- mem_req_rw  in  1  1 = write, 0 = read.
- mem_req_byteen  in  DATA_WIDTH/8  write byte enables.
- mem_req_addr  in  ADDR_WIDTH  line address.
- mem_req_data  in  DATA_WIDTH  write data.
- mem_req_tag  in  TAG_WIDTH  request tag.
- mem_rsp_valid  out  1  read response valid.
- mem_rsp_data  out  DATA_WIDTH  read data.
- mem_rsp_tag  out  TAG_WIDTH  tag of the originating read.
- mem_rsp_ready  in  1  consumer accepts the response.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  reads accepted but not yet returned.
- busy  out  1  outstanding != 0.

Behaviour:
- Reset: with reset_n low, mem_rsp_valid=0, outstanding=0, busy=0, mem_req_ready=0, queue emptied. mem_rsp_data/tag are don't-care. Memory array is not reset.
- mem_req_ready=1 iff out of reset and outstanding < MAX_OUTSTANDING. Ready is registered state only; it does not depend on mem_req_valid.
- Ready is deasserted for writes too while the queue is full. Keeps the ordering rule simple.
- Index = mem_req_addr[MEM_DEPTH_LOG2-1:0]; upper address bits are ignored (aliasing).
- Write accept (rw=1): at that clock edge, byte lane i of line[index] is updated iff byteen[i]. No response is generated. outstanding is unchanged.
- Read accept (rw=0): line[index] is sampled at the accept edge, using pre-write contents. An entry {data, tag, countdown=LATENCY-1} is pushed to the tail of the queue.
  - Reads to a line written in an earlier cycle return the new data.
- Countdown: every cycle, every valid entry decrements its countdown, saturating at 0.
- Response: mem_rsp_valid=1 iff the head entry is valid and its countdown==0. mem_rsp_data/tag come from the head entry.
  - On valid && rsp_ready the head is popped.
  - Responses are strictly in accept order.
  - Read accepted at edge T gives first possible rsp_valid in cycle T+LATENCY.
- Backpressure: while rsp_ready=0, mem_rsp_valid and data/tag are held stable. Younger entries keep counting down, so they can issue back-to-back once the stall releases.
- outstanding: +1 on read accept, -1 on response handshake. Unchanged when both occur in the same cycle. It never exceeds MAX_OUTSTANDING.
- Full: push and pop in the same cycle when full is impossible, since ready=0. A pop while full raises ready the next cycle.
- Reset asserted mid-operation: all in-flight reads are dropped immediately (async). No response for them ever appears after reset release.
- Throughput: one request per cycle and one response per cycle sustained.

Decomposition:
- Package vx_mem_model_pkg holds:
  - rsp_entry_t typedef: data, tag, countdown[7:0], valid.
  - Constant LAT_CNT_W=8.
  - Helper function for the byte-enable merge.
- Sub-module vx_mem_rsp_queue: a MAX_OUTSTANDING-entry circular FIFO of rsp_entry_t with per-entry countdown, head_ready output, push/pop, and count.
- The top level holds the storage array, write merge, and handshake logic.

Test Plan:
- Reset with LATENCY=4: hold reset_n=0 for 3 cycles -> rsp_valid=0, outstanding=0, ready=0 during reset; ready=1 on the first cycle after release.
- Write then read: write line 5, byteen=all ones, data=0xA5.., then read line 5 tag=0x11 accepted at T -> rsp_valid at T+4 exactly, data=0xA5.., tag=0x11.
- Partial write: preload line 3 to all 0x00; write byteen=0x...0F with data all 0xFF; read -> bytes 0..3 = 0xFF, rest 0x00.
- Full queue, MAX_OUTSTANDING=8, rsp_ready=0:
  - Issue 9 reads -> ready drops after the 8th accept; outstanding=8; busy=1.
  - Raise rsp_ready -> 8 responses on consecutive cycles with tags in issue order.
  - ready rises one cycle after the first pop.
- Simultaneous accept and pop with outstanding=3 -> outstanding stays 3.
- Reset mid-flight: 2 reads outstanding, pulse reset_n low for 1 cycle -> rsp_valid never asserts for those tags; outstanding=0 after reset.
